// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, qualifies it, then releases sys_rst.
// Define PLL_LOCK_FILTER_EN to ignore lock drops of 3 or fewer cycles while running.
module pll_reset_ctrl #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W               = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       timeout_err,
   output logic [7:0] relock_count
);

   localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

   typedef enum logic [1:0] {
      StResetPll,
      StWaitLock,
      StStableCheck,
      StRun
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, locked_sync_q;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             timeout_err_q, timeout_err_d;
   logic [7:0]       relock_count_q, relock_count_d;
   logic             lost;

`ifdef PLL_LOCK_FILTER_EN
   logic [1:0] loss_q, loss_d;

   // Only the fourth consecutive low sample counts as a real loss of lock.
   assign lost = !locked_sync_q && (loss_q == 2'd3);
`else
   assign lost = !locked_sync_q;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pll_rst_d      = pll_rst_q;
      sys_rst_d      = sys_rst_q;
      ready_d        = ready_q;
      timeout_err_d  = timeout_err_q;
      relock_count_d = relock_count_q;
`ifdef PLL_LOCK_FILTER_EN
      loss_d         = 2'd0;
`endif
      unique case (state_q)
         StResetPll: begin
            pll_rst_d = 1'b1;
            sys_rst_d = 1'b1;
            ready_d   = 1'b0;
            if (cnt_q == PulseLast) begin
               cnt_d     = '0;
               state_d   = StWaitLock;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StWaitLock: begin
            pll_rst_d = 1'b0;
            if (locked_sync_q) begin
               cnt_d   = '0;
               state_d = StStableCheck;
            end else if (cnt_q == TimeoutLast) begin
               timeout_err_d = 1'b1;
               cnt_d         = '0;
               state_d       = StResetPll;
               pll_rst_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StStableCheck: begin
            if (!locked_sync_q) begin
               cnt_d   = '0;
               state_d = StWaitLock;
            end else if (cnt_q == StableLast) begin
               cnt_d     = '0;
               state_d   = StRun;
               sys_rst_d = 1'b0;
               ready_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StRun: begin
            cnt_d = '0;
`ifdef PLL_LOCK_FILTER_EN
            if (!locked_sync_q) begin
               loss_d = loss_q + 2'd1;
            end
`endif
            if (lost) begin
               state_d   = StResetPll;
               pll_rst_d = 1'b1;
               sys_rst_d = 1'b1;
               ready_d   = 1'b0;
`ifdef PLL_LOCK_FILTER_EN
               loss_d    = 2'd0;
`endif
               if (relock_count_q != 8'hFF) begin
                  relock_count_d = relock_count_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = StResetPll;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q        <= 1'b0;
         locked_sync_q  <= 1'b0;
         state_q        <= StResetPll;
         cnt_q          <= '0;
         pll_rst_q      <= 1'b1;
         sys_rst_q      <= 1'b1;
         ready_q        <= 1'b0;
         timeout_err_q  <= 1'b0;
         relock_count_q <= 8'd0;
`ifdef PLL_LOCK_FILTER_EN
         loss_q         <= 2'd0;
`endif
      end else begin
         sync1_q        <= pll_locked;
         locked_sync_q  <= sync1_q;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pll_rst_q      <= pll_rst_d;
         sys_rst_q      <= sys_rst_d;
         ready_q        <= ready_d;
         timeout_err_q  <= timeout_err_d;
         relock_count_q <= relock_count_d;
`ifdef PLL_LOCK_FILTER_EN
         loss_q         <= loss_d;
`endif
      end
   end

   assign pll_rst      = pll_rst_q;
   assign sys_rst      = sys_rst_q;
   assign ready        = ready_q;
   assign timeout_err  = timeout_err_q;
   assign relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed and randomized lock patterns checked every cycle against
// a phase/timestamp model of the sequencer.
module tb_pll_reset_ctrl;

   localparam int P = 8;
   localparam int S = 16;
   localparam int T = 64;
`ifdef PLL_LOCK_FILTER_EN
   localparam int LossN   = 4;
   localparam int LossLat = 6;
`else
   localparam int LossN   = 1;
   localparam int LossLat = 3;
`endif

   localparam int PhPulse = 0;
   localparam int PhWait  = 1;
   localparam int PhStab  = 2;
   localparam int PhRun   = 3;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, ready, timeout_err;
   logic [7:0] relock_count;

   int checks = 0;
   int errors = 0;

   // Reference model: current phase, edge at which it was entered, and sticky status.
   int edge_n = 0;
   int m_phase = PhPulse;
   int m_t0 = 0;
   int m_lows = 0;
   int m_relock = 0;
   bit m_terr = 1'b0;
   bit m_s1 = 1'b0;
   bit m_s2 = 1'b0;

   pll_reset_ctrl #(
      .RST_PULSE_CYCLES   (P),
      .LOCK_STABLE_CYCLES (S),
      .LOCK_TIMEOUT_CYCLES(T),
      .CNT_W              (8)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .timeout_err (timeout_err),
      .relock_count(relock_count)
   );

   always #10 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic enter(input int ph);
      m_phase = ph;
      m_t0    = edge_n;
      m_lows  = 0;
   endtask

   task automatic model_edge();
      int el;
      bit ls;
      edge_n++;
      if (rst) begin
         enter(PhPulse);
         m_terr   = 1'b0;
         m_relock = 0;
         m_s1     = 1'b0;
         m_s2     = 1'b0;
      end else begin
         ls = m_s2;
         el = edge_n - m_t0;
         case (m_phase)
            PhPulse: if (el == P) enter(PhWait);
            PhWait: begin
               if (ls) enter(PhStab);
               else if (el == T) begin
                  m_terr = 1'b1;
                  enter(PhPulse);
               end
            end
            PhStab: begin
               if (!ls) enter(PhWait);
               else if (el == S) enter(PhRun);
            end
            default: begin
               m_lows = ls ? 0 : m_lows + 1;
               if (m_lows == LossN) begin
                  if (m_relock < 255) m_relock++;
                  enter(PhPulse);
               end
            end
         endcase
         m_s2 = m_s1;
         m_s1 = pll_locked;
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      model_edge();
      #1;
      check("pll_rst", pll_rst, m_phase == PhPulse);
      check("sys_rst", sys_rst, m_phase != PhRun);
      check("ready", ready, m_phase == PhRun);
      check("timeout_err", timeout_err, m_terr);
      check("relock_count", relock_count, m_relock);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready && k < 300) begin
         tick();
         k++;
      end
      check("wait_ready", ready, 1);
   endtask

   task automatic wait_stable(input int cnt);
      int k = 0;
      while (!(m_phase == PhStab && edge_n - m_t0 == cnt + 1) && k < 300) begin
         tick();
         k++;
      end
      check("reach_stable_check", m_phase, PhStab);
   endtask

   task automatic drop(input int len);
      pll_locked = 1'b0;
      repeat (len) tick();
      pll_locked = 1'b1;
   endtask

   initial begin
      int k;
      int first_fall;
      int len;

      // Power-up lock with pll_locked high throughout.
      rst = 1'b1;
      pll_locked = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      k = 0;
      first_fall = -1;
      while (!ready && k < 100) begin
         tick();
         k++;
         if (first_fall < 0 && !pll_rst) first_fall = k;
      end
      check("pll_rst_fall_edge", first_fall, P);
      check("ready_rise_edge", k, P + S + 1);
      check("powerup_sys_rst", sys_rst, 0);
      check("powerup_timeout_err", timeout_err, 0);
      check("powerup_relock", relock_count, 0);

      // Lock never arrives: repeated pulse/timeout windows.
      rst = 1'b1;
      pll_locked = 1'b0;
      tick();
      rst = 1'b0;
      repeat (2 * (P + T) + 5) tick();
      check("timeout_sticky", timeout_err, 1);
      check("timeout_no_ready", ready, 0);

      // Lock drops briefly during stable qualification.
      pll_locked = 1'b1;
      wait_stable(10);
      drop($urandom_range(1, 3));
      wait_ready();

      // Exact lock-loss latency from the pll_locked fall to sys_rst.
      pll_locked = 1'b0;
      k = 0;
      while (!sys_rst && k < 20) begin
         if (k == 4) pll_locked = 1'b1;
         tick();
         k++;
      end
      pll_locked = 1'b1;
      check("loss_latency", k, LossLat);
      check("loss_pll_rst", pll_rst, 1);
      wait_ready();

      // Randomized drops while running, short and long.
      repeat (8) begin
         repeat ($urandom_range(0, 20)) tick();
         drop($urandom_range(1, 6));
         wait_ready();
      end

      // Saturate relock_count.
      repeat (262) begin
         wait_ready();
         drop(4 + $urandom_range(0, 2));
      end
      wait_ready();
      check("relock_saturated", relock_count, 255);

      // Reset during stable qualification.
      drop(5);
      wait_stable($urandom_range(0, S - 2));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_pll_rst", pll_rst, 1);
      check("mid_rst_sys_rst", sys_rst, 1);
      check("mid_rst_relock", relock_count, 0);

      // Set timeout_err, then reset while running.
      pll_locked = 1'b0;
      repeat (P + T + 3) tick();
      pll_locked = 1'b1;
      wait_ready();
      check("run_timeout_err_set", timeout_err, 1);
      repeat ($urandom_range(1, 10)) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("run_rst_ready", ready, 0);
      check("run_rst_timeout_err", timeout_err, 0);
      check("run_rst_sys_rst", sys_rst, 1);

      // Random lock bursts with occasional resets.
      repeat (400) begin
         pll_locked = ($urandom_range(0, 3) != 0);
         len = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 8);
         repeat (len) begin
            rst = ($urandom_range(0, 299) == 0);
            tick();
         end
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
